// File: rtl/vend_pkg.sv
// Shared types and table helpers for the multi-product vending controller.
// Tables are packed vectors; helpers slice one entry out by index.
package vend_pkg;

    localparam int TBL_W = 512;

    typedef enum logic [1:0] {
        ST_INSUF         = 2'b00,
        ST_CHANGE        = 2'b01,
        ST_BOUGHT        = 2'b10,
        ST_BOUGHT_CHANGE = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        VEND   = 2'b01,
        CHANGE = 2'b10
    } state_e;

    // Entry idx of width w from a packed table; callers zero-extend to TBL_W.
    function automatic logic [31:0] tbl_entry(input logic [TBL_W-1:0] tbl, input int idx, input int w);
        logic [TBL_W-1:0] s;
        logic [31:0]      mask;
        s    = tbl >> (idx * w);
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return s[31:0] & mask;
    endfunction

    function automatic logic [31:0] price_of(input logic [TBL_W-1:0] tbl, input int idx, input int w);
        return tbl_entry(tbl, idx, w);
    endfunction

    function automatic logic [31:0] coin_val(input logic [TBL_W-1:0] tbl, input int idx, input int w);
        return tbl_entry(tbl, idx, w);
    endfunction

    function automatic logic idx_ok(input int idx, input int n);
        return idx < n;
    endfunction

endpackage

// File: rtl/vend_credit.sv
// Credit register: one add or subtract per cycle, plus an overflow look-ahead
// for a candidate amount. Add wins if both are requested.
module vend_credit
    import vend_pkg::*;
#(
    parameter int CW         = 8,
    parameter int MAX_CREDIT = 200
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          add_i,
    input  logic          sub_i,
    input  logic [CW-1:0] amt_i,
    input  logic [CW-1:0] chk_amt_i,
    output logic [CW-1:0] credit_o,
    output logic          fits_o
);

    localparam logic [CW:0] MAXC = (CW+1)'(MAX_CREDIT);

    logic [CW-1:0] credit_q;
    logic [CW-1:0] credit_d;

    // One extra bit so the sum can never wrap before the compare.
    assign fits_o   = ({1'b0, credit_q} + {1'b0, chk_amt_i}) <= MAXC;
    assign credit_o = credit_q;

    always_comb begin
        credit_d = credit_q;
        if (add_i) begin
            credit_d = credit_q + amt_i;
        end else if (sub_i) begin
            credit_d = credit_q - amt_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: coin credit, priced selection with
// dispense handshake, and unit-coin change return. All outputs registered.
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int                   N_PROD     = 4,
    parameter int                   CW         = 8,
    parameter logic [N_PROD*CW-1:0] PRICE      = {8'd30, 8'd25, 8'd20, 8'd15},
    parameter logic [4*CW-1:0]      COIN_VAL   = {8'd0, 8'd25, 8'd10, 8'd5},
    parameter int                   CHG_UNIT   = 5,
    parameter int                   MAX_CREDIT = 200,
    localparam int                  SW         = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic          c,
    input  logic          r,
    input  logic          coin_valid,
    input  logic [1:0]    coin_sel,
    input  logic          sel_valid,
    input  logic [SW-1:0] sel,
    input  logic          cancel,
    input  logic          disp_done,
    output logic          dispense,
    output logic [SW-1:0] disp_id,
    output logic          chg_pulse,
    output logic          coin_reject,
    output logic [CW-1:0] credit,
    output logic [1:0]    status,
    output logic          busy
);

    localparam logic [CW-1:0] UNIT = CW'(CHG_UNIT);

    state_e        state_q, state_d;
    status_e       status_q, status_d;
    logic          dispense_q, dispense_d;
    logic [SW-1:0] disp_id_q, disp_id_d;
    logic          chg_q, chg_d;
    logic          rej_q, rej_d;
    logic          busy_q;

    logic          cr_add, cr_sub, cr_fits;
    logic [CW-1:0] cr_amt, coin_v, price_v, credit_v;
    logic          sel_buy;

    vend_credit #(
        .CW         (CW),
        .MAX_CREDIT (MAX_CREDIT)
    ) u_credit (
        .clk_i     (c),
        .rst_ni    (r),
        .add_i     (cr_add),
        .sub_i     (cr_sub),
        .amt_i     (cr_amt),
        .chk_amt_i (coin_v),
        .credit_o  (credit_v),
        .fits_o    (cr_fits)
    );

    assign coin_v  = CW'(coin_val(TBL_W'(COIN_VAL), int'(coin_sel), CW));
    assign price_v = CW'(price_of(TBL_W'(PRICE), int'(sel), CW));
    assign sel_buy = sel_valid && idx_ok(int'(sel), N_PROD) && (credit_v >= price_v);

    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        dispense_d = dispense_q;
        disp_id_d  = disp_id_q;
        chg_d      = 1'b0;
        rej_d      = 1'b0;
        cr_add     = 1'b0;
        cr_sub     = 1'b0;
        cr_amt     = '0;
        case (state_q)
            IDLE: begin
                // Selection outranks cancel, which outranks a coin in the same cycle.
                if (sel_buy) begin
                    cr_sub     = 1'b1;
                    cr_amt     = price_v;
                    disp_id_d  = sel;
                    dispense_d = 1'b1;
                    rej_d      = coin_valid;
                    state_d    = VEND;
                end else if (cancel && (credit_v != '0)) begin
                    status_d = ST_CHANGE;
                    rej_d    = coin_valid;
                    state_d  = CHANGE;
                end else begin
                    if (sel_valid) begin
                        status_d = ST_INSUF;
                    end
                    if (coin_valid) begin
                        if ((coin_v != '0) && cr_fits) begin
                            cr_add   = 1'b1;
                            cr_amt   = coin_v;
                            status_d = ST_INSUF;
                        end else begin
                            rej_d = 1'b1;
                        end
                    end
                end
            end
            VEND: begin
                rej_d = coin_valid;
                if (disp_done) begin
                    dispense_d = 1'b0;
                    if (credit_v != '0) begin
                        status_d = ST_BOUGHT_CHANGE;
                        state_d  = CHANGE;
                    end else begin
                        status_d = ST_BOUGHT;
                        state_d  = IDLE;
                    end
                end
            end
            CHANGE: begin
                rej_d = coin_valid;
                if (credit_v >= UNIT) begin
                    chg_d  = 1'b1;
                    cr_sub = 1'b1;
                    cr_amt = UNIT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge c) begin
        if (!r) begin
            state_q    <= IDLE;
            status_q   <= ST_INSUF;
            dispense_q <= 1'b0;
            disp_id_q  <= '0;
            chg_q      <= 1'b0;
            rej_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            dispense_q <= dispense_d;
            disp_id_q  <= disp_id_d;
            chg_q      <= chg_d;
            rej_q      <= rej_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    assign dispense    = dispense_q;
    assign disp_id     = disp_id_q;
    assign chg_pulse   = chg_q;
    assign coin_reject = rej_q;
    assign credit      = credit_v;
    assign status      = status_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Bench for vend_ctrl_multi: directed vector table, corner sequences, and
// randomized traffic against a behavioural model of the vending rules.
module tb_vend_ctrl_multi;

    logic       c = 1'b0;
    logic       r;
    logic       coin_valid;
    logic [1:0] coin_sel;
    logic       sel_valid;
    logic [1:0] sel;
    logic       cancel;
    logic       disp_done;
    logic       dispense;
    logic [1:0] disp_id;
    logic       chg_pulse;
    logic       coin_reject;
    logic [7:0] credit;
    logic [1:0] status;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 c = ~c;

    vend_ctrl_multi dut (
        .c           (c),
        .r           (r),
        .coin_valid  (coin_valid),
        .coin_sel    (coin_sel),
        .sel_valid   (sel_valid),
        .sel         (sel),
        .cancel      (cancel),
        .disp_done   (disp_done),
        .dispense    (dispense),
        .disp_id     (disp_id),
        .chg_pulse   (chg_pulse),
        .coin_reject (coin_reject),
        .credit      (credit),
        .status      (status),
        .busy        (busy)
    );

    typedef struct {
        logic       cv;
        logic [1:0] cs;
        logic       sv;
        logic [1:0] s;
        logic       cn;
        logic       dd;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[31];

    // Packed view: {dispense, disp_id, chg_pulse, coin_reject, credit, status, busy}
    function automatic logic [15:0] pk(logic d, logic [1:0] id, logic ch, logic rj,
                                       logic [7:0] cr, logic [1:0] st, logic b);
        return {d, id, ch, rj, cr, st, b};
    endfunction

    function automatic vec_t mk(logic cv, logic [1:0] cs, logic sv, logic [1:0] s,
                                logic cn, logic dd, logic [15:0] exp);
        vec_t v;
        v.cv = cv; v.cs = cs; v.sv = sv; v.s = s; v.cn = cn; v.dd = dd; v.exp = exp;
        return v;
    endfunction

    function automatic logic [15:0] obs();
        return {dispense, disp_id, chg_pulse, coin_reject, credit, status, busy};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic cv, input logic [1:0] cs, input logic sv,
                         input logic [1:0] s, input logic cn, input logic dd);
        coin_valid = cv; coin_sel = cs; sel_valid = sv; sel = s; cancel = cn; disp_done = dd;
        @(posedge c);
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        r = 1'b0;
        idle();
        idle();
        r = 1'b1;
    endtask

    task automatic count_pulses(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            idle();
            if (chg_pulse) n++;
            if (!busy) break;
        end
    endtask

    // Reference model: phase 0 waiting for customer, 1 product handed off, 2 refunding
    int price_t[4] = '{15, 20, 25, 30};
    int coin_t[4]  = '{5, 10, 25, 0};
    int m_phase, m_credit, m_disp, m_id, m_chg, m_rej, m_status;

    task automatic m_reset();
        m_phase = 0; m_credit = 0; m_disp = 0; m_id = 0; m_chg = 0; m_rej = 0; m_status = 0;
    endtask

    task automatic m_step();
        int cval;
        int pr;
        cval  = coin_t[coin_sel];
        pr    = price_t[sel];
        m_rej = 0;
        m_chg = 0;
        if (!r) begin
            m_reset();
        end else if (m_phase == 0) begin
            if (sel_valid && m_credit >= pr) begin
                m_credit -= pr; m_id = sel; m_disp = 1; m_phase = 1; m_rej = coin_valid;
            end else if (cancel && m_credit > 0) begin
                m_status = 1; m_phase = 2; m_rej = coin_valid;
            end else begin
                if (sel_valid) m_status = 0;
                if (coin_valid) begin
                    if (cval != 0 && m_credit + cval <= 200) begin
                        m_credit += cval; m_status = 0;
                    end else begin
                        m_rej = 1;
                    end
                end
            end
        end else if (m_phase == 1) begin
            m_rej = coin_valid;
            if (disp_done) begin
                m_disp = 0;
                if (m_credit > 0) begin m_status = 3; m_phase = 2; end
                else begin m_status = 2; m_phase = 0; end
            end
        end else begin
            m_rej = coin_valid;
            if (m_credit >= 5) begin m_chg = 1; m_credit -= 5; end
            else m_phase = 0;
        end
    endtask

    initial begin
        int n;
        r = 1'b0;
        coin_valid = 0; coin_sel = 0; sel_valid = 0; sel = 0; cancel = 0; disp_done = 0;

        tbl[0]  = mk(1, 1, 0, 0, 0, 0, pk(0, 0, 0, 0, 10, 0, 0));
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 15, 0, 0));
        tbl[2]  = mk(0, 0, 1, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 1));
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, pk(1, 0, 0, 0, 0, 0, 1));
        tbl[4]  = mk(0, 0, 0, 0, 0, 1, pk(0, 0, 0, 0, 0, 2, 0));
        tbl[5]  = mk(1, 2, 0, 0, 0, 0, pk(0, 0, 0, 0, 25, 0, 0));
        tbl[6]  = mk(1, 1, 0, 0, 0, 0, pk(0, 0, 0, 0, 35, 0, 0));
        tbl[7]  = mk(0, 0, 1, 1, 0, 0, pk(1, 1, 0, 0, 15, 0, 1));
        tbl[8]  = mk(0, 0, 0, 0, 0, 1, pk(0, 1, 0, 0, 15, 3, 1));
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, pk(0, 1, 1, 0, 10, 3, 1));
        tbl[10] = mk(0, 0, 0, 0, 0, 0, pk(0, 1, 1, 0, 5, 3, 1));
        tbl[11] = mk(0, 0, 0, 0, 0, 0, pk(0, 1, 1, 0, 0, 3, 1));
        tbl[12] = mk(0, 0, 0, 0, 0, 0, pk(0, 1, 0, 0, 0, 3, 0));
        tbl[13] = mk(0, 0, 0, 0, 0, 0, pk(0, 1, 0, 0, 0, 3, 0));
        tbl[14] = mk(1, 0, 0, 0, 0, 0, pk(0, 1, 0, 0, 5, 0, 0));
        tbl[15] = mk(0, 0, 1, 3, 0, 0, pk(0, 1, 0, 0, 5, 0, 0));
        tbl[16] = mk(0, 0, 0, 0, 1, 0, pk(0, 1, 0, 0, 5, 1, 1));
        tbl[17] = mk(0, 0, 0, 0, 0, 0, pk(0, 1, 1, 0, 0, 1, 1));
        tbl[18] = mk(0, 0, 0, 0, 0, 0, pk(0, 1, 0, 0, 0, 1, 0));
        tbl[19] = mk(1, 1, 0, 0, 0, 0, pk(0, 1, 0, 0, 10, 0, 0));
        tbl[20] = mk(1, 1, 0, 0, 0, 0, pk(0, 1, 0, 0, 20, 0, 0));
        tbl[21] = mk(1, 1, 1, 1, 0, 0, pk(1, 1, 0, 1, 0, 0, 1));
        tbl[22] = mk(1, 0, 0, 0, 0, 0, pk(1, 1, 0, 1, 0, 0, 1));
        tbl[23] = mk(0, 0, 0, 0, 0, 0, pk(1, 1, 0, 0, 0, 0, 1));
        tbl[24] = mk(0, 0, 0, 0, 0, 1, pk(0, 1, 0, 0, 0, 2, 0));
        tbl[25] = mk(1, 0, 0, 0, 0, 0, pk(0, 1, 0, 0, 5, 0, 0));
        tbl[26] = mk(1, 1, 0, 0, 1, 0, pk(0, 1, 0, 1, 5, 1, 1));
        tbl[27] = mk(0, 0, 0, 0, 0, 0, pk(0, 1, 1, 0, 0, 1, 1));
        tbl[28] = mk(0, 0, 0, 0, 0, 0, pk(0, 1, 0, 0, 0, 1, 0));
        tbl[29] = mk(1, 3, 0, 0, 0, 0, pk(0, 1, 0, 1, 0, 1, 0));
        tbl[30] = mk(0, 0, 1, 0, 0, 0, pk(0, 1, 0, 0, 0, 0, 0));

        do_reset();
        chk("reset_state", obs(), 16'h0000);

        // Reset landing in the middle of change return
        apply(1, 1, 0, 0, 0, 0);
        apply(1, 1, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 1, 0);
        idle();
        chk("pre_reset_change", obs(), pk(0, 0, 1, 0, 15, 1, 1));
        r = 1'b0;
        idle();
        chk("reset_mid_change", obs(), 16'h0000);
        r = 1'b1;
        idle();
        chk("after_reset_idle", obs(), 16'h0000);

        do_reset();
        for (int i = 0; i < 31; i++) begin
            apply(tbl[i].cv, tbl[i].cs, tbl[i].sv, tbl[i].s, tbl[i].cn, tbl[i].dd);
            chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
        end

        // Credit ceiling: 190, then overflow and invalid coin, then exact fill to 200
        for (int i = 0; i < 7; i++) apply(1, 2, 0, 0, 0, 0);
        apply(1, 1, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        chk("credit_190", 16'(credit), 16'd190);
        apply(1, 2, 0, 0, 0, 0);
        chk("overflow_reject", {7'd0, coin_reject, credit}, {7'd0, 1'b1, 8'd190});
        apply(1, 3, 0, 0, 0, 0);
        chk("invalid_coin_reject", {7'd0, coin_reject, credit}, {7'd0, 1'b1, 8'd190});
        apply(1, 1, 0, 0, 0, 0);
        chk("fill_to_max", {7'd0, coin_reject, credit}, {7'd0, 1'b0, 8'd200});
        apply(1, 0, 0, 0, 0, 0);
        chk("over_max_by_5", {7'd0, coin_reject, credit}, {7'd0, 1'b1, 8'd200});
        apply(0, 0, 0, 0, 1, 0);
        count_pulses(n);
        chk("refund_200_pulses", 16'(n), 16'd40);
        chk("refund_200_end", {7'd0, busy, credit}, 16'd0);

        apply(1, 2, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 1, 0);
        count_pulses(n);
        chk("refund_25_pulses", 16'(n), 16'd5);

        // Randomized traffic against the model
        do_reset();
        m_reset();
        for (int i = 0; i < 3000; i++) begin
            r          = ($urandom_range(0, 199) != 0);
            coin_valid = ($urandom_range(0, 1) == 1);
            coin_sel   = 2'($urandom_range(0, 3));
            sel_valid  = ($urandom_range(0, 4) == 0);
            sel        = 2'($urandom_range(0, 3));
            cancel     = !sel_valid && ($urandom_range(0, 9) == 0);
            disp_done  = ($urandom_range(0, 3) == 0);
            m_step();
            @(posedge c);
            #1;
            chk($sformatf("rand%0d", i), obs(),
                pk(m_disp[0], 2'(m_id), m_chg[0], m_rej[0], 8'(m_credit), 2'(m_status), m_phase != 0));
        end
        r = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
